// File: rtl/ara_pkg.sv
// Shared lane definitions: instruction ID tag type and the mask-port indices of the functional units.
package ara_pkg;

    localparam int NrVInsn = 8;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    localparam int NrMaskFUnits = 2;
    localparam int MaskFUAlu    = 0;
    localparam int MaskFUMFpu   = 1;

endpackage

// File: rtl/vfu_mask_fifo.sv
// Per-FU mask buffer: circular FIFO of Depth entries with flush and a stale-head drop port.
module vfu_mask_fifo #(
    parameter int  Depth   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  logic   drop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            advance;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count == '0);
    assign full_o  = (count == CntW'(Depth));
    assign advance = (pop_i | drop_i) & ~empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (advance) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_i && !advance) begin
                count <= count + CntW'(1);
            end else if (!push_i && advance) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Routes tagged mask beats from the mask unit into one buffer per functional unit, matched on instruction ID.
module vfu_mask_router
    import ara_pkg::*;
#(
    parameter int NrFUs     = NrMaskFUnits,
    parameter int MaskDepth = 2,
    parameter int StrbWidth = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [StrbWidth-1:0]            mask_i,
    input  vid_t                            mask_vid_i,
    input  logic                            mask_valid_i,
    output logic                            mask_ready_o,
    input  vid_t [NrFUs-1:0]                fu_vid_i,
    input  logic [NrFUs-1:0]                fu_vid_valid_i,
    input  logic [NrFUs-1:0]                fu_flush_i,
    output logic [NrFUs-1:0][StrbWidth-1:0] fu_mask_o,
    output logic [NrFUs-1:0]                fu_mask_valid_o,
    input  logic [NrFUs-1:0]                fu_mask_ready_i,
    output logic                            multi_match_o
);

    localparam int VidW   = $bits(vid_t);
    localparam int EntryW = StrbWidth + VidW;
    localparam int TgtW   = (NrFUs > 1) ? $clog2(NrFUs) : 1;

    logic [NrFUs-1:0]  match;
    logic [NrFUs-1:0]  full;
    logic [NrFUs-1:0]  empty;
    logic [NrFUs-1:0]  push;
    logic [NrFUs-1:0]  pop;
    logic [NrFUs-1:0]  drop;
    logic [NrFUs-1:0]  head_ok;
    logic [EntryW-1:0] head [NrFUs];
    logic [TgtW-1:0]   target;
    logic              any_match;
    logic              multi_match_q;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        target = '0;
        for (int f = NrFUs - 1; f >= 0; f--) begin
            if (match[f]) begin
                target = TgtW'(f);
            end
        end
    end

    assign any_match    = |match;
    assign mask_ready_o = any_match & ~fu_flush_i[target] & (~full[target] | pop[target]);

    for (genvar f = 0; f < NrFUs; f++) begin : gen_fu
        vid_t head_vid;

        assign match[f]           = mask_valid_i & fu_vid_valid_i[f] & (fu_vid_i[f] == mask_vid_i);
        assign push[f]            = mask_valid_i & mask_ready_o & (target == TgtW'(f));
        assign head_vid           = head[f][VidW-1:0];
        assign head_ok[f]         = fu_vid_valid_i[f] & (head_vid == fu_vid_i[f]);
        assign fu_mask_valid_o[f] = ~empty[f] & head_ok[f];
        assign fu_mask_o[f]       = head[f][EntryW-1:VidW];
        assign pop[f]             = fu_mask_valid_o[f] & fu_mask_ready_i[f];
        // A head whose tag no longer belongs to the FU can never be consumed.
        assign drop[f]            = ~empty[f] & ~head_ok[f];

        vfu_mask_fifo #(
            .Depth   (MaskDepth),
            .entry_t (logic [EntryW-1:0])
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[f]),
            .data_i  ({mask_i, mask_vid_i}),
            .pop_i   (pop[f]),
            .flush_i (fu_flush_i[f]),
            .drop_i  (drop[f]),
            .full_o  (full[f]),
            .empty_o (empty[f]),
            .head_o  (head[f])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_match_q <= 1'b0;
        end else if ((match & (match - NrFUs'(1))) != '0) begin
            multi_match_q <= 1'b1;
        end
    end

    assign multi_match_o = multi_match_q;

endmodule

// File: doc/vfu_mask_router.md
Name: vfu_mask_router

Overview:
- Routes tagged mask-byte strobes from the lane's mask-unit interface to NrFUs functional units (ALU, MFPU, future FUs).
- Each FU has its own buffer, so concurrent masked instructions in different FUs no longer share one untagged mask broadcast.
- Sits in the lane execution stage between the mask unit's mask_i stream and each FU's mask port; replaces the OR-ed shared mask_ready.

Parameters:
- NrFUs, 2, number of functional units with a mask port (index 0 = ALU, 1 = MFPU).
- MaskDepth, 2, entries per FU buffer; any value >= 1, not restricted to powers of two.
- StrbWidth, 8, mask bits per beat (DataWidth/8 for 64-bit elen).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- mask_i  in  StrbWidth  mask beat from mask unit.
- mask_vid_i  in  vid_t  instruction ID tag of mask beat.
- mask_valid_i  in  1  beat valid.
- mask_ready_o  out  1  beat accepted.
- fu_vid_i  in  NrFUs x vid_t  ID of masked instruction currently active in each FU.
- fu_vid_valid_i  in  NrFUs  FU has an active masked instruction.
- fu_flush_i  in  NrFUs  FU instruction done or killed; clear that FU's buffer.
- fu_mask_o  out  NrFUs x StrbWidth  head-of-buffer mask per FU.
- fu_mask_valid_o  out  NrFUs  head valid per FU.
- fu_mask_ready_i  in  NrFUs  FU consumes head.
- multi_match_o  out  1  sticky error: a tag matched more than one FU.

Behaviour:
- Reset: all buffers empty (count 0, pointers 0), fu_mask_valid_o = 0, mask_ready_o = 0, multi_match_o = 0. Reset mid-operation discards all buffered beats.
- Match: match[f] = mask_valid_i & fu_vid_valid_i[f] & (fu_vid_i[f] == mask_vid_i). Target is the lowest-index f with match[f].
- Multiple matches: route to the lowest index. Set multi_match_o at the next edge; it clears only on reset.
- No match: mask_ready_o = 0 and the beat is held upstream until some FU claims the tag. No beat is ever dropped.
- Accept rule: mask_ready_o = any match & ~fu_flush_i[target] & (~full[target] | pop[target]).
  - Push-while-full is allowed when the same FU pops that cycle.
  - This creates a deliberate combinational path from fu_mask_ready_i to mask_ready_o.
- Push: on mask_valid_i & mask_ready_o, write {mask_i, mask_vid_i} at wr_ptr[target]. Visible at fu_mask_valid_o the next cycle (1-cycle latency, no bypass).
- Pop: pop[f] = fu_mask_valid_o[f] & fu_mask_ready_i[f]; advances rd_ptr.
- Head qualification: fu_mask_valid_o[f] = ~empty[f] & fu_vid_valid_i[f] & (head_vid[f] == fu_vid_i[f]).
- Stale head: if ~empty[f] and the head tag differs from fu_vid_i[f] (or fu_vid_valid_i[f] = 0), the head is silently dropped, one entry per cycle.
- fu_mask_o[f] = head mask, regardless of valid.
- Pointers wrap from MaskDepth-1 to 0. Count width = $clog2(MaskDepth+1). Simultaneous push and pop leaves count unchanged.
- Flush: fu_flush_i[f] empties buffer f at the next edge (count 0, pointers 0). Flush wins over push and pop in the same cycle; a beat targeting f is not accepted that cycle.
- Buffers are independent: a full or stalled FU never blocks beats for another FU.

Decomposition:
- ara_pkg holds vid_t, NrMaskFUnits (= NrFUs default), and the MaskFUAlu / MaskFUMFpu indices. No new typedefs are needed.
- One sub-module, vfu_mask_fifo, instantiated NrFUs times. Parameters: Depth, entry type. Ports: push/pop/flush, full/empty, head, plus the stale-drop input.
- The top level holds the tag matching, target selection, ready generation and the sticky error flag.

Test Plan:
- Reset then idle: all outputs 0. Push beat 0xA5, tag 3, with FU0 active on vid 3 → fu_mask_valid_o[0] = 1 the next cycle, fu_mask_o[0] = 0xA5, FU1 unaffected.
- Concurrent FUs: FU0 on vid 1, FU1 on vid 2. Alternate beats 0x11(t1), 0x22(t2), 0x33(t1) → FU0 receives 0x11 then 0x33, FU1 receives 0x22, in order.
- Full plus simultaneous pop (MaskDepth = 2): fill FU1 with 0x01, 0x02, hold fu_mask_ready_i[1] = 0 → third beat stalls. Raise fu_mask_ready_i[1] → third beat is accepted the same cycle; count stays 2.
- Unmatched tag 5 with no FU on vid 5 → mask_ready_o stays 0 for 10 cycles. FU1 switches to vid 5 → accepted next cycle.
- Flush race: FU0 holds two beats. Assert fu_flush_i[0] together with a matching push and fu_mask_ready_i[0] = 1 → buffer empty next cycle, push not accepted, no valid.
- Stale and multi-match: leave beat t4 in FU0, switch FU0 to vid 6 → entry dropped, valid never asserted. Give FU0 and FU1 the same vid 7 and push 0xFF → routed to FU0; multi_match_o = 1 and stays set.
